ram_readback: RTL and testbench

RAM_READBACK -- requirements
Module: ram_readback

---
 rtl/ram_readback_pkg.sv | 23 ++
 rtl/ram_readback_if.sv | 30 +++
 rtl/ram_readback_ctr.sv | 36 +++
 rtl/ram_readback.sv | 140 ++++++++++++++
 tb/tb_ram_readback.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_readback_pkg.sv
// rtl/ram_readback_pkg.sv - shared RAM geometry defaults and readback FSM state encoding
package ram_readback_pkg;

   // Geometry shared with the CPU-side RAM
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   // Width of the modulo-256 stream checksum
   localparam int CSUM_W = 8;

   // Readback FSM encoding; SUM only exists when the checksum word is built in
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
`ifdef READBACK_CHECKSUM_EN
      ST_SUM  = 3'd4,
`endif
      ST_FIN  = 3'd5
   } state_e;

endpackage

// File: rtl/ram_readback_if.sv
// rtl/ram_readback_if.sv - RAM read port, stream output and status signals of the readback engine
interface ram_readback_if
   import ram_readback_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] content;
   logic [DATA_W-1:0] dout;
   logic [ADDR_W-1:0] daddr;
   logic              dvalid;
   logic              dready;
   logic              dlast;
   logic              busy;
   logic              done;

   // Readback engine side
   modport master (
      input  start, content, dready,
      output addr, dout, daddr, dvalid, dlast, busy, done
   );

   // RAM model / stream consumer side
   modport slave (
      output start, content, dready,
      input  addr, dout, daddr, dvalid, dlast, busy, done
   );
endinterface

// File: rtl/ram_readback_ctr.sv
// rtl/ram_readback_ctr.sv - readback address counter with load-to-zero, saturating increment and terminal count
module readback_ctr #(
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] cnt_o,
   output logic              tc_o
);
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   // The counter stops at the last address instead of wrapping, so Addr keeps pointing there afterwards
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (inc_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = &cnt_q;
endmodule

// File: rtl/ram_readback.sv
// rtl/ram_readback.sv - streams every RAM word with its address; optional trailing checksum word under READBACK_CHECKSUM_EN
module ram_readback
   import ram_readback_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   ram_readback_if.master rb_io
);
   state_e            state_q;
   logic [1:0]        wait_q;
   logic [DATA_W-1:0] dout_q;
   logic [ADDR_W-1:0] daddr_q;
   logic              dvalid_q;
   logic              dlast_q;
   logic              busy_q;
   logic              done_q;
`ifdef READBACK_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_q;
`endif

   logic              ctr_load;
   logic              ctr_inc;
   logic              ctr_tc;
   logic [ADDR_W-1:0] ctr_cnt;
   logic              xfer;

   assign xfer     = dvalid_q & rb_io.dready;
   assign ctr_load = (state_q == ST_IDLE) & rb_io.start;
   assign ctr_inc  = (state_q == ST_SEND) & xfer;

   readback_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (ctr_load),
      .inc_i  (ctr_inc),
      .cnt_o  (ctr_cnt),
      .tc_o   (ctr_tc)
   );

   // Readback sequencer: issue address, wait out the RAM latency, offer the word, advance on accept
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         wait_q   <= '0;
         dout_q   <= '0;
         daddr_q  <= '0;
         dvalid_q <= 1'b0;
         dlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rb_io.start) begin
                  busy_q  <= 1'b1;
`ifdef READBACK_CHECKSUM_EN
                  csum_q  <= '0;
`endif
                  state_q <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // Addr already shows the counter; WAIT covers the RAM read latency
               wait_q  <= 2'(RD_LAT - 1);
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_q == 2'd0) begin
                  dout_q   <= rb_io.content;
                  daddr_q  <= ctr_cnt;
                  dvalid_q <= 1'b1;
`ifdef READBACK_CHECKSUM_EN
                  dlast_q  <= 1'b0;
                  csum_q   <= csum_q + CSUM_W'(rb_io.content);
`else
                  dlast_q  <= ctr_tc;
`endif
                  state_q  <= ST_SEND;
               end else begin
                  wait_q <= wait_q - 2'd1;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  dvalid_q <= 1'b0;
                  dlast_q  <= 1'b0;
                  if (!ctr_tc) begin
                     state_q <= ST_ADDR;
                  end else begin
`ifdef READBACK_CHECKSUM_EN
                     // The checksum already includes the last data word, so it can be offered at once
                     dout_q   <= DATA_W'(csum_q);
                     daddr_q  <= '0;
                     dlast_q  <= 1'b1;
                     dvalid_q <= 1'b1;
                     state_q  <= ST_SUM;
`else
                     done_q  <= 1'b1;
                     state_q <= ST_FIN;
`endif
                  end
               end
            end
`ifdef READBACK_CHECKSUM_EN
            ST_SUM: begin
               if (xfer) begin
                  dvalid_q <= 1'b0;
                  dlast_q  <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_FIN;
               end
            end
`endif
            ST_FIN: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rb_io.addr   = ctr_cnt;
   assign rb_io.dout   = dout_q;
   assign rb_io.daddr  = daddr_q;
   assign rb_io.dvalid = dvalid_q;
   assign rb_io.dlast  = dlast_q;
   assign rb_io.busy   = busy_q;
   assign rb_io.done   = done_q;
endmodule

// File: tb/tb_ram_readback.sv
// tb/tb_ram_readback.sv - self-checking bench for ram_readback at RD_LAT 1 and 3
module tb_ram_readback;
   import ram_readback_pkg::*;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
`ifdef READBACK_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int NWORDS = DEPTH + (CSUM ? 1 : 0);
   localparam logic [7:0] FIB [DEPTH] = '{8'hBF, 8'h0E, 8'hE0, 8'hBD, 8'h8D, 8'hBF, 8'h0E, 8'hE0,
                                         8'hBD, 8'h8F, 8'hBE, 8'hAC, 8'h04, 8'h00, 8'h01, 8'h01};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic dready = 1'b0;
   logic sel = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
   ram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

   ram_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .rb_io(if1.master));
   ram_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .rb_io(if3.master));

   // RAM models: registered read pipelines of depth 1 and 3
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] pipe1;
   logic [DW-1:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= mem[if1.addr];
      pipe3[0] <= mem[if3.addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign if1.content = pipe1;
   assign if3.content = pipe3[2];
   assign if1.start   = start & ~sel;
   assign if3.start   = start & sel;
   assign if1.dready  = dready;
   assign if3.dready  = dready;

   wire [AW-1:0] o_addr   = sel ? if3.addr   : if1.addr;
   wire [AW-1:0] o_daddr  = sel ? if3.daddr  : if1.daddr;
   wire [DW-1:0] o_dout   = sel ? if3.dout   : if1.dout;
   wire          o_dvalid = sel ? if3.dvalid : if1.dvalid;
   wire          o_dlast  = sel ? if3.dlast  : if1.dlast;
   wire          o_busy   = sel ? if3.busy   : if1.busy;
   wire          o_done   = sel ? if3.done   : if1.done;

   // Stream recorder: accepted words, Done pulses, and words that changed or vanished while stalled
   logic [AW-1:0] q_addr [$];
   logic [DW-1:0] q_data [$];
   logic          q_last [$];
   int            done_cnt = 0;
   int            hold_err = 0;
   logic          hold_p = 1'b0;
   logic          rst_p = 1'b0;
   logic [AW-1:0] h_addr = '0;
   logic [DW-1:0] h_data = '0;
   logic          h_last = 1'b0;
   always @(negedge clk) begin
      if (o_dvalid && dready && rst_n) begin
         q_addr.push_back(o_daddr);
         q_data.push_back(o_dout);
         q_last.push_back(o_dlast);
      end
      if (o_done) done_cnt <= done_cnt + 1;
      if (hold_p && rst_p && (!o_dvalid || o_daddr !== h_addr || o_dout !== h_data || o_dlast !== h_last))
         hold_err <= hold_err + 1;
      hold_p <= o_dvalid && !dready && rst_n;
      rst_p  <= rst_n;
      h_addr <= o_daddr;
      h_data <= o_dout;
      h_last <= o_dlast;
   end

   // Reference stream: every address in order, then the modulo-256 sum when enabled
   logic [AW-1:0] ea [$];
   logic [DW-1:0] ed [$];
   logic          el [$];
   function automatic void build_model();
      int sum;
      sum = 0;
      ea.delete(); ed.delete(); el.delete();
      for (int a = 0; a < DEPTH; a++) begin
         ea.push_back(AW'(a));
         ed.push_back(mem[a]);
         el.push_back(!CSUM && (a == DEPTH - 1));
         sum = (sum + int'(mem[a])) % 256;
      end
      if (CSUM) begin
         ea.push_back('0);
         ed.push_back(DW'(sum));
         el.push_back(1'b1);
      end
   endfunction

   function automatic void clear_q();
      q_addr.delete(); q_data.delete(); q_last.delete();
   endfunction

   function automatic void load_fib();
      for (int a = 0; a < DEPTH; a++) mem[a] = FIB[a];
   endfunction

   function automatic void load_rand();
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom_range(0, 255));
   endfunction

   task automatic kick(output int lat);
      lat = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (o_dvalid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic wait_done(input bit rnd, input int d0, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
         if (rnd) dready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      dready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (o_addr   !== '0)   begin n_err++; $display("FAIL reset_addr: got %h exp 0", o_addr); end
      n_cmp++; if (o_dout   !== '0)   begin n_err++; $display("FAIL reset_dout: got %h exp 0", o_dout); end
      n_cmp++; if (o_daddr  !== '0)   begin n_err++; $display("FAIL reset_daddr: got %h exp 0", o_daddr); end
      n_cmp++; if (o_dvalid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid: got %b exp 0", o_dvalid); end
      n_cmp++; if (o_dlast  !== 1'b0) begin n_err++; $display("FAIL reset_dlast: got %b exp 0", o_dlast); end
      n_cmp++; if (o_busy   !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
      n_cmp++; if (o_done   !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", o_done); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_fib_stream();
      int lat; int d0; bit ok;
      load_fib(); build_model(); clear_q();
      dready = 1'b1; d0 = done_cnt;
      kick(lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fib_latency: got %0d exp 2", lat); end
      wait_done(1'b0, d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fib_timeout: got no Done exp Done"); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL fib_done_count: got %0d exp %0d", done_cnt - d0, 1); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL fib_busy_idle: got %b exp 0", o_busy); end
      n_cmp++; if (o_addr !== AW'(DEPTH - 1)) begin n_err++; $display("FAIL fib_addr_hold: got %0d exp %0d", o_addr, DEPTH - 1); end
      n_cmp++; if (q_data.size() != NWORDS) begin n_err++; $display("FAIL fib_count: got %0d exp %0d", q_data.size(), NWORDS); end
      foreach (ea[i]) if (i < q_data.size()) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== el[i]) begin
            n_err++;
            $display("FAIL fib_word%0d: got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat; int d0; int stall; int h0;
      load_fib(); build_model(); clear_q();
      dready = 1'b1; d0 = done_cnt; h0 = hold_err; stall = 0;
      kick(lat);
      for (int c = 0; c < 600 && done_cnt == d0; c++) begin
         if (o_dvalid && o_daddr == 3 && stall < 5) begin
            dready = 1'b0;
            stall++;
            n_cmp++;
            if (o_dout !== 8'hBD) begin n_err++; $display("FAIL bp_stall_dout%0d: got %h exp bd", stall, o_dout); end
         end else begin
            dready = 1'b1;
         end
         @(posedge clk); #1;
      end
      dready = 1'b1;
      n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL bp_done: got %0d exp 1", done_cnt - d0); end
      n_cmp++; if (stall !== 5) begin n_err++; $display("FAIL bp_stall_cycles: got %0d exp 5", stall); end
      n_cmp++; if (hold_err !== h0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles exp 0", hold_err - h0); end
      n_cmp++; if (q_data.size() != NWORDS) begin n_err++; $display("FAIL bp_count: got %0d exp %0d", q_data.size(), NWORDS); end
      foreach (ea[i]) if (i < q_data.size()) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== el[i]) begin
            n_err++;
            $display("FAIL bp_word%0d: got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat; int d0; bit ok; bit found;
      load_fib(); build_model(); clear_q();
      dready = 1'b1; d0 = done_cnt; found = 1'b0;
      kick(lat);
      for (int c = 0; c < 300; c++) begin
         if (o_dvalid && o_daddr == 7) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rstmid_reach7: got no word 7 exp word 7"); end
      dready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (o_dvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_dvalid: got %b exp 0", o_dvalid); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b exp 0", o_busy); end
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses exp 0", done_cnt - d0); end
      clear_q();
      dready = 1'b1;
      kick(lat);
      n_cmp++; if (o_daddr !== '0) begin n_err++; $display("FAIL rstmid_restart_addr: got %0d exp 0", o_daddr); end
      wait_done(1'b0, d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_timeout: got no Done exp Done"); end
      n_cmp++; if (q_data.size() != NWORDS) begin n_err++; $display("FAIL rstmid_count: got %0d exp %0d", q_data.size(), NWORDS); end
      foreach (ea[i]) if (i < q_data.size()) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== el[i]) begin
            n_err++;
            $display("FAIL rstmid_word%0d: got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int lat; int d0; bit mid; bit fin;
      load_fib(); build_model(); clear_q();
      dready = 1'b1; d0 = done_cnt; mid = 1'b0; fin = 1'b0;
      kick(lat);
      for (int c = 0; c < 600 && done_cnt == d0; c++) begin
         start = 1'b0;
         if (o_dvalid && o_daddr == 5 && !mid) begin
            start = 1'b1;
            mid = 1'b1;
         end
         if (o_done && !fin) begin
            start = 1'b1;
            fin = 1'b1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL ign_fin_seen: got %b exp 1", fin); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %b exp 0", o_busy); end
      n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL ign_done_count: got %0d exp 1", done_cnt - d0); end
      n_cmp++; if (q_data.size() != NWORDS) begin n_err++; $display("FAIL ign_count: got %0d exp %0d", q_data.size(), NWORDS); end
      foreach (ea[i]) if (i < q_data.size()) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== el[i]) begin
            n_err++;
            $display("FAIL ign_word%0d: got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_random(input int iters, input int exp_lat);
      int lat; int d0; int h0; bit ok;
      for (int it = 0; it < iters; it++) begin
         if (it == 0 && sel) load_fib(); else load_rand();
         build_model(); clear_q();
         d0 = done_cnt; h0 = hold_err;
         dready = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         kick(lat);
         n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d exp %0d", it, lat, exp_lat); end
         wait_done(it != 0, d0, ok);
         n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rnd%0d_timeout: got no Done exp Done", it); end
         n_cmp++; if (hold_err !== h0) begin n_err++; $display("FAIL rnd%0d_hold: got %0d unstable cycles exp 0", it, hold_err - h0); end
         n_cmp++; if (q_data.size() != NWORDS) begin n_err++; $display("FAIL rnd%0d_count: got %0d exp %0d", it, q_data.size(), NWORDS); end
         foreach (ea[i]) if (i < q_data.size()) begin
            n_cmp++;
            if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_last[i] !== el[i]) begin
               n_err++;
               $display("FAIL rnd%0d_word%0d: got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", it, i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], el[i]);
            end
         end
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_rd_lat3();
      sel = 1'b1;
      @(posedge clk); #1;
      test_random(3, 4);
      sel = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_fib_stream();
      test_backpressure();
      test_reset_mid();
      test_start_ignored();
      test_random(5, 2);
      test_rd_lat3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
